// File: rtl/bus_arbiter.sv
// Two-master, one-slave bus sequencer: grants fetch (M1) or memory (M2), runs a
// registered address/wait/response sequence, and aborts on slave timeout.
module bus_arbiter #(
  parameter int ADDR_W       = 64,
  parameter int DATA_W       = 64,
  parameter int STARVE_LIMIT = 4,
  parameter int TIMEOUT      = 16
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              M1_HTRANS,
  input  logic [ADDR_W-1:0] M1_HADDR,
  output logic              M1_HREADY,
  output logic [DATA_W-1:0] M1_HRDATA,
  input  logic              M2_HTRANS,
  input  logic [ADDR_W-1:0] M2_HADDR,
  input  logic              M2_HWRITE,
  input  logic [2:0]        M2_HSIZE,
  input  logic [DATA_W-1:0] M2_HWDATA,
  output logic              M2_HREADY,
  output logic [DATA_W-1:0] M2_HRDATA,
  output logic              S_HTRANS,
  output logic [ADDR_W-1:0] S_HADDR,
  output logic              S_HWRITE,
  output logic [2:0]        S_HSIZE,
  output logic [DATA_W-1:0] S_HWDATA,
  input  logic [DATA_W-1:0] S_HRDATA,
  input  logic              S_HREADY,
  output logic [1:0]        owner,
  output logic              err,
  output logic              stall,
  output logic [1:0]        dbg_state
);

  localparam int SW = $clog2(STARVE_LIMIT + 1);
  localparam int TW = $clog2(TIMEOUT);
  localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIMIT);
  localparam logic [TW-1:0] TIMER_MAX  = TW'(TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE = 2'd0, BUSY = 2'd1, RESP = 2'd2} state_t;

  state_t            state, state_n;
  logic [SW-1:0]     starve_cnt, starve_n;
  logic [TW-1:0]     timer, timer_n;
  logic              s_htrans_n, s_hwrite_n, m1_hready_n, m2_hready_n, err_n;
  logic [ADDR_W-1:0] s_haddr_n;
  logic [2:0]        s_hsize_n;
  logic [DATA_W-1:0] s_hwdata_n, m1_hrdata_n, m2_hrdata_n, rsp_data;
  logic [1:0]        owner_n;

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state      <= IDLE;
      starve_cnt <= '0;
      timer      <= '0;
      S_HTRANS   <= 1'b0;
      S_HADDR    <= '0;
      S_HWRITE   <= 1'b0;
      S_HSIZE    <= 3'd0;
      S_HWDATA   <= '0;
      M1_HREADY  <= 1'b0;
      M1_HRDATA  <= '0;
      M2_HREADY  <= 1'b0;
      M2_HRDATA  <= '0;
      owner      <= 2'b00;
      err        <= 1'b0;
    end else begin
      state      <= state_n;
      starve_cnt <= starve_n;
      timer      <= timer_n;
      S_HTRANS   <= s_htrans_n;
      S_HADDR    <= s_haddr_n;
      S_HWRITE   <= s_hwrite_n;
      S_HSIZE    <= s_hsize_n;
      S_HWDATA   <= s_hwdata_n;
      M1_HREADY  <= m1_hready_n;
      M1_HRDATA  <= m1_hrdata_n;
      M2_HREADY  <= m2_hready_n;
      M2_HRDATA  <= m2_hrdata_n;
      owner      <= owner_n;
      err        <= err_n;
    end
  end

  always_comb begin
    state_n     = state;
    starve_n    = starve_cnt;
    timer_n     = timer;
    s_htrans_n  = S_HTRANS;
    s_haddr_n   = S_HADDR;
    s_hwrite_n  = S_HWRITE;
    s_hsize_n   = S_HSIZE;
    s_hwdata_n  = S_HWDATA;
    m1_hready_n = M1_HREADY;
    m1_hrdata_n = M1_HRDATA;
    m2_hready_n = M2_HREADY;
    m2_hrdata_n = M2_HRDATA;
    owner_n     = owner;
    err_n       = err;
    rsp_data    = '0;
    case (state)
      IDLE: begin
        // M2 has priority unless M1 has already been passed over STARVE_LIMIT times.
        if (M1_HTRANS && (!M2_HTRANS || starve_cnt == STARVE_MAX)) begin
          s_haddr_n  = M1_HADDR;
          s_hwrite_n = 1'b0;
          s_hsize_n  = 3'd3;
          s_hwdata_n = '0;
          owner_n    = 2'b01;
          starve_n   = '0;
          s_htrans_n = 1'b1;
          timer_n    = '0;
          state_n    = BUSY;
        end else if (M2_HTRANS) begin
          s_haddr_n  = M2_HADDR;
          s_hwrite_n = M2_HWRITE;
          s_hsize_n  = M2_HSIZE;
          s_hwdata_n = M2_HWDATA;
          owner_n    = 2'b10;
          if (!M1_HTRANS)
            starve_n = '0;
          else if (starve_cnt != STARVE_MAX)
            starve_n = starve_cnt + 1'b1;
          s_htrans_n = 1'b1;
          timer_n    = '0;
          state_n    = BUSY;
        end else if (!M1_HTRANS) begin
          starve_n = '0;
        end
      end
      BUSY: begin
        timer_n = timer + 1'b1;
        if (S_HREADY || timer == TIMER_MAX) begin
          // Writes and aborted transfers return zero data.
          rsp_data   = (S_HREADY && !S_HWRITE) ? S_HRDATA : '0;
          err_n      = !S_HREADY;
          s_htrans_n = 1'b0;
          state_n    = RESP;
          if (owner == 2'b01) begin
            m1_hready_n = 1'b1;
            m1_hrdata_n = rsp_data;
          end else begin
            m2_hready_n = 1'b1;
            m2_hrdata_n = rsp_data;
          end
        end
      end
      RESP: begin
        m1_hready_n = 1'b0;
        m2_hready_n = 1'b0;
        err_n       = 1'b0;
        owner_n     = 2'b00;
        state_n     = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  assign stall     = (M1_HTRANS & ~M1_HREADY) | (M2_HTRANS & ~M2_HREADY);
  assign dbg_state = state;

endmodule
